// File: rtl/ws2812b_tx_peripheral.sv
// WS2812B transmitter peripheral with a TinyQV byte register interface.
// Software loads G/R/B and an LED count, then writes a start bit. The block
// sends GRB x count as NRZ pulse-width bits on uo_out[1], MSB first, then
// holds the line low for the latch period.
//
// Register interface: data_write is a one-cycle write strobe, and data_in is
// sampled on the same clock edge. There is no back-pressure. data_out is a
// combinational decode of address. Reading 0xF (address==0xF, data_write=0)
// clears the done flag on the next edge.
module ws2812b_tx_peripheral #(
    parameter int CLK_HZ       = 64000000,
    parameter int T0H_CYCLES   = 26,
    parameter int T1H_CYCLES   = 51,
    parameter int BIT_CYCLES   = 80,
    parameter int RESET_CYCLES = 3840
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    // The phase counter must reach the longest phase, which is the latch period.
    localparam int PW = $clog2(RESET_CYCLES + 1);
    localparam logic [PW-1:0] T0H_M1 = PW'(T0H_CYCLES - 1);
    localparam logic [PW-1:0] T1H_M1 = PW'(T1H_CYCLES - 1);
    localparam logic [PW-1:0] T0L_M1 = PW'(BIT_CYCLES - T0H_CYCLES - 1);
    localparam logic [PW-1:0] T1L_M1 = PW'(BIT_CYCLES - T1H_CYCLES - 1);
    localparam logic [PW-1:0] RST_M1 = PW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HIGH  = 2'd1,
        S_LOW   = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_reg_r;
    logic [7:0]      r_reg_g;
    logic [7:0]      r_reg_b;
    logic [7:0]      r_reg_count;
    logic [7:0]      r_sh_r;
    logic [7:0]      r_sh_g;
    logic [7:0]      r_sh_b;
    logic [23:0]     r_shift;
    logic [4:0]      r_bit_cnt;
    logic [7:0]      r_led_left;
    logic [PW-1:0]   r_phase;
    logic            r_busy;
    logic            r_done;
    logic            r_dout;
    logic            w_start_ok;
    logic            w_phase_end;
    logic            w_frame_end;
    logic            w_rd_status;
    logic [PW-1:0]   w_th_m1;
    logic [PW-1:0]   w_tl_m1;
    logic            w_unused;

    // ui_in and CLK_HZ are not used by the logic.
    assign w_unused = &{1'b0, ui_in, (CLK_HZ > 0)};

    assign w_start_ok  = data_write && (address == 4'h4) && data_in[0]
                         && (r_state == S_IDLE) && (r_reg_count != 8'd0);
    assign w_rd_status = (address == 4'hF) && !data_write;
    assign w_th_m1     = r_shift[23] ? T1H_M1 : T0H_M1;
    assign w_tl_m1     = r_shift[23] ? T1L_M1 : T0L_M1;
    assign w_frame_end = (r_state == S_LATCH) && w_phase_end;
    assign uo_out      = {6'b0, r_dout, 1'b0};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic and end-of-phase detection.
    always_comb begin
        w_next_state = r_state;
        w_phase_end  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next_state = S_HIGH;
            end
            S_HIGH: begin
                if (r_phase == w_th_m1) begin
                    w_phase_end  = 1'b1;
                    w_next_state = S_LOW;
                end
            end
            S_LOW: begin
                if (r_phase == w_tl_m1) begin
                    w_phase_end = 1'b1;
                    if ((r_bit_cnt != 5'd23) || (r_led_left > 8'd1)) w_next_state = S_HIGH;
                    else                                             w_next_state = S_LATCH;
                end
            end
            S_LATCH: begin
                if (r_phase == RST_M1) begin
                    w_phase_end  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Bit datapath: output register, phase counter, shift register and LED counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout     <= 1'b0;
            r_phase    <= '0;
            r_shift    <= 24'd0;
            r_bit_cnt  <= 5'd0;
            r_led_left <= 8'd0;
            r_sh_r     <= 8'd0;
            r_sh_g     <= 8'd0;
            r_sh_b     <= 8'd0;
        end else begin
            // Output is high exactly while the FSM is in HIGH.
            r_dout <= (w_next_state == S_HIGH);
            if (w_start_ok || w_phase_end) r_phase <= '0;
            else if (r_state != S_IDLE)    r_phase <= r_phase + 1'b1;
            if (w_start_ok) begin
                r_sh_r     <= r_reg_r;
                r_sh_g     <= r_reg_g;
                r_sh_b     <= r_reg_b;
                r_shift    <= {r_reg_g, r_reg_r, r_reg_b};
                r_bit_cnt  <= 5'd0;
                r_led_left <= r_reg_count;
            end else if ((r_state == S_LOW) && w_phase_end) begin
                if (r_bit_cnt != 5'd23) begin
                    r_shift   <= {r_shift[22:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end else if (r_led_left > 8'd1) begin
                    r_shift    <= {r_sh_g, r_sh_r, r_sh_b};
                    r_bit_cnt  <= 5'd0;
                    r_led_left <= r_led_left - 8'd1;
                end
            end
        end
    end

    // Software-visible colour and count registers; writable at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_r     <= 8'd0;
            r_reg_g     <= 8'd0;
            r_reg_b     <= 8'd0;
            r_reg_count <= 8'd1;
        end else if (data_write) begin
            case (address)
                4'h0:    r_reg_r     <= data_in;
                4'h1:    r_reg_g     <= data_in;
                4'h2:    r_reg_b     <= data_in;
                4'h3:    r_reg_count <= data_in;
                default: ;
            endcase
        end
    end

    // Busy/done status; a completion beats a same-cycle read-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_start_ok)       r_busy <= 1'b1;
            else if (w_frame_end) r_busy <= 1'b0;
            if (w_frame_end)      r_done <= 1'b1;
            else if (w_start_ok)  r_done <= 1'b0;
            else if (w_rd_status) r_done <= 1'b0;
        end
    end

    // Read decode.
    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0:    data_out = r_reg_r;
            4'h1:    data_out = r_reg_g;
            4'h2:    data_out = r_reg_b;
            4'h3:    data_out = r_reg_count;
            4'hF:    data_out = {6'b0, r_done, r_busy};
            default: data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_ws2812b_tx_peripheral.sv
// Bench for ws2812b_tx_peripheral. Each accepted start pushes the expected
// high time of every bit in the frame into exp_q. A monitor measures every
// pulse on uo_out[1], pops the queue and checks the high time and the bit
// period. The main process checks register reads and frame length.
module tb_ws2812b_tx_peripheral;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int         n_checks = 0;
    int         n_pass   = 0;
    longint     cyc      = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_r, m_g, m_b, m_count;
    logic       m_busy;
    longint     m_start_cyc;
    int         m_len;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812b_tx_peripheral dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    // Model of a register write, including start acceptance.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        logic [23:0] grb;
        @(negedge clk);
        address = a; data_in = d; data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0; address = 4'h0;
        case (a)
            4'h0: m_r = d;
            4'h1: m_g = d;
            4'h2: m_b = d;
            4'h3: m_count = d;
            4'h4: begin
                if (d[0] && !m_busy && (m_count != 8'd0)) begin
                    grb = {m_g, m_r, m_b};
                    for (int l = 0; l < int'(m_count); l++)
                        for (int i = 23; i >= 0; i--)
                            exp_q.push_back(grb[i] ? 8'd51 : 8'd26);
                    m_busy      = 1'b1;
                    m_start_cyc = cyc;
                    m_len       = int'(m_count) * 24 * 80 + 3840;
                end
            end
            default: ;
        endcase
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input int exp);
        @(negedge clk);
        address = a; data_write = 1'b0;
        #1;
        check(name, int'(data_out), exp);
    endtask

    // Poll status until done, then check frame length and read-clear.
    task automatic wait_done(input string name);
        logic first;
        logic timed_out;
        first = 1'b1;
        timed_out = 1'b0;
        @(negedge clk);
        address = 4'hF; data_write = 1'b0;
        while (1) begin
            @(posedge clk);
            #1;
            if (data_out[1]) break;
            if (first) begin
                check({name, " busy status"}, int'(data_out), 1);
                first = 1'b0;
            end
            if (cyc - m_start_cyc > longint'(m_len + 200)) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (timed_out) begin
            check({name, " done timeout"}, 0, 1);
        end else begin
            check({name, " frame length"}, int'(cyc - m_start_cyc), m_len);
            check({name, " done status"}, int'(data_out), 2);
            @(posedge clk);
            #1;
            check({name, " done read-clear"}, int'(data_out), 0);
        end
        m_busy = 1'b0;
    endtask

    // Pulse monitor: pops one expected high time per pulse, checks period.
    int   mon_hi = 0;
    int   mon_lo = 9999;
    int   mon_hi_last = 0;
    logic mon_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev = 1'b0;
            mon_hi   = 0;
            mon_lo   = 9999;
        end else begin
            if (uo_out[1]) begin
                if (!mon_prev) begin
                    if (mon_lo < 1000) check("bit period", mon_hi_last + mon_lo, 80);
                    mon_hi = 0;
                end
                mon_hi++;
            end else begin
                if (mon_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected pulse", mon_hi, 0);
                    end else begin
                        check("pulse high time", mon_hi, int'(exp_q.pop_front()));
                    end
                    mon_hi_last = mon_hi;
                    mon_lo      = 0;
                end
                if (mon_lo < 9999) mon_lo++;
            end
            mon_prev = uo_out[1];
        end
    end

    initial begin
        logic quiet;
        rst_n = 1'b0; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
        ui_in = 8'($urandom);
        m_r = 8'h00; m_g = 8'h00; m_b = 8'h00; m_count = 8'h01; m_busy = 1'b0;
        m_start_cyc = 0; m_len = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        check("reset uo_out", int'(uo_out), 0);
        rd_check("reset R", 4'h0, 0);
        rd_check("reset G", 4'h1, 0);
        rd_check("reset B", 4'h2, 0);
        rd_check("reset count", 4'h3, 1);
        rd_check("reset status", 4'hF, 0);

        // Single LED with known pattern.
        wr(4'h1, 8'h80); wr(4'h0, 8'h00); wr(4'h2, 8'h01); wr(4'h3, 8'h01);
        rd_check("readback G", 4'h1, 8'h80);
        rd_check("readback B", 4'h2, 8'h01);
        rd_check("unmapped addr", 4'h7, 0);
        wr(4'h4, 8'h01);
        check("uo_out other bits", int'(uo_out & 8'hFD), 0);
        wait_done("single");

        // Three LEDs, all ones.
        wr(4'h0, 8'hFF); wr(4'h1, 8'hFF); wr(4'h2, 8'hFF); wr(4'h3, 8'h03);
        wr(4'h4, 8'h01);
        wait_done("multi");

        // Start while busy is dropped; colour write shadows to next frame.
        wr(4'h1, 8'hAA); wr(4'h0, 8'h0F); wr(4'h2, 8'h3C); wr(4'h3, 8'h01);
        wr(4'h4, 8'h01);
        repeat (100) @(negedge clk);
        wr(4'h1, 8'h55);
        wr(4'h4, 8'h01);
        rd_check("G during frame", 4'h1, 8'h55);
        wait_done("shadow first");
        wr(4'h4, 8'h01);
        wait_done("shadow second");

        // Randomized frames.
        repeat (3) begin
            wr(4'h0, 8'($urandom)); wr(4'h1, 8'($urandom)); wr(4'h2, 8'($urandom));
            wr(4'h3, 8'($urandom_range(1, 2)));
            wr(4'h4, 8'h01);
            wait_done("random");
        end

        // Count zero: start is ignored.
        wr(4'h3, 8'h00);
        rd_check("count zero readback", 4'h3, 0);
        wr(4'h4, 8'h01);
        quiet = 1'b1;
        @(negedge clk);
        address = 4'hF;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (uo_out[1] || (data_out != 8'h00)) quiet = 1'b0;
        end
        check("count zero idle", int'(quiet), 1);

        // Reset in the middle of a HIGH phase.
        wr(4'h1, 8'hF0); wr(4'h3, 8'h02);
        wr(4'h4, 8'h01);
        repeat (10) @(negedge clk);
        check("line high before reset", int'(uo_out[1]), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_r = 8'h00; m_g = 8'h00; m_b = 8'h00; m_count = 8'h01; m_busy = 1'b0;
        #1;
        check("async reset dout", int'(uo_out[1]), 0);
        rd_check("mid reset G", 4'h1, 0);
        rd_check("mid reset count", 4'h3, 1);
        rd_check("mid reset status", 4'hF, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        rd_check("no done after reset", 4'hF, 0);

        // One more frame after reset.
        wr(4'h1, 8'($urandom)); wr(4'h2, 8'h81);
        wr(4'h4, 8'h01);
        wait_done("post reset");

        repeat (5) @(negedge clk);
        check("expected queue drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
